// File: rtl/conv_8_32_if.sv
// Byte-in / word-out bundle for the conv_8_32 packer.
// The master side drives bytes; the slave side (the packer) returns assembled words and status.
interface conv_8_32_if;
   logic [7:0]  in_data8;
   logic        in8;
   logic [31:0] out_data32;
   logic        out32;
   logic        busy;
   logic        gap_err;

   modport master (
      output in_data8, in8,
      input  out_data32, out32, busy, gap_err
   );

   modport slave (
      input  in_data8, in8,
      output out_data32, out32, busy, gap_err
   );
endinterface

// File: rtl/conv_8_32.sv
// Packs a qualified 8-bit byte stream into 32-bit words, emitting a one-cycle out32 per word.
// Optional partial-word timeout is enabled by defining CONV_8_32_GAP_ABORT_EN.
module conv_8_32 #(
   parameter int MSB_FIRST = 1,
   parameter int GAP_MAX   = 8
) (
   input logic        clk,
   input logic        reset,
   conv_8_32_if.slave bus
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic [31:0] shift_reg;
   logic [31:0] word_next;
   logic [31:0] out_word;
   logic        out_vld;
   logic        busy_r;
   logic [4:0]  slot_pos;

   if (GAP_MAX < 1 || GAP_MAX > 255) begin : g_bad_gap_max
      $error("conv_8_32: GAP_MAX must be in 1..255");
   end

   // Merge the incoming byte into its slot; on the 4th byte this becomes the finished word.
   always_comb begin
      slot_pos  = (MSB_FIRST != 0) ? (5'd24 - {cnt, 3'b000}) : {cnt, 3'b000};
      word_next = shift_reg;
      word_next[slot_pos +: 8] = bus.in_data8;
   end

`ifdef CONV_8_32_GAP_ABORT_EN
   localparam logic [7:0] GAP_LAST = 8'(GAP_MAX - 1);
   logic [7:0] gap_cnt;
   logic       gap_err_r;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         shift_reg <= 32'h0;
         out_word  <= 32'h0;
         out_vld   <= 1'b0;
         busy_r    <= 1'b0;
`ifdef CONV_8_32_GAP_ABORT_EN
         gap_cnt   <= 8'd0;
         gap_err_r <= 1'b0;
`endif
      end else begin
         out_vld <= 1'b0;
`ifdef CONV_8_32_GAP_ABORT_EN
         gap_err_r <= 1'b0;
`endif
         if (bus.in8) begin
`ifdef CONV_8_32_GAP_ABORT_EN
            gap_cnt <= 8'd0;
`endif
            if (cnt == 2'd3) begin
               // Finished word goes straight to the output register, so the next
               // word can start assembling without disturbing the presented one.
               out_word  <= word_next;
               out_vld   <= 1'b1;
               shift_reg <= 32'h0;
               cnt       <= 2'd0;
               state     <= IDLE;
               busy_r    <= 1'b0;
            end else begin
               shift_reg <= word_next;
               cnt       <= cnt + 2'd1;
               state     <= ACCUM;
               busy_r    <= 1'b1;
            end
         end
`ifdef CONV_8_32_GAP_ABORT_EN
         else if (state == ACCUM) begin
            if (gap_cnt == GAP_LAST) begin
               shift_reg <= 32'h0;
               cnt       <= 2'd0;
               state     <= IDLE;
               busy_r    <= 1'b0;
               gap_cnt   <= 8'd0;
               gap_err_r <= 1'b1;
            end else begin
               gap_cnt <= gap_cnt + 8'd1;
            end
         end
`endif
      end
   end

   assign bus.out_data32 = out_word;
   assign bus.out32      = out_vld;
   assign bus.busy       = busy_r;
`ifdef CONV_8_32_GAP_ABORT_EN
   assign bus.gap_err    = gap_err_r;
`else
   assign bus.gap_err    = 1'b0;
`endif

endmodule

// File: tb/tb_conv_8_32.sv
// Self-checking bench for conv_8_32: fixed vector table, corner-case sequences and a random run
// compared against a byte-queue reference model; an MSB_FIRST=0 instance shares the stimulus.
module tb_conv_8_32;

   localparam int GAP_MAX = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   conv_8_32_if bus ();
   conv_8_32_if bus_lsb ();

   assign bus_lsb.in_data8 = bus.in_data8;
   assign bus_lsb.in8      = bus.in8;

   conv_8_32 #(.MSB_FIRST(1), .GAP_MAX(GAP_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   conv_8_32 #(.MSB_FIRST(0), .GAP_MAX(GAP_MAX)) dut_lsb (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_lsb.slave)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: bytes accepted so far for the current word, plus the idle run length.
   logic [7:0]  byte_q[$];
   int          idle_run = 0;
   logic [31:0] m_word_msb = 32'h0;
   logic [31:0] m_word_lsb = 32'h0;
   logic        m_out32 = 1'b0;
   logic        m_err = 1'b0;
   logic        m_busy = 1'b0;

   typedef struct {
      logic        rst;
      logic        v;
      logic [7:0]  d;
      logic        e_out32;
      logic [31:0] e_word;
      logic        e_busy;
   } vec_t;

   vec_t vecs[15];

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelStep(input logic r, input logic v, input logic [7:0] d);
      m_out32 = 1'b0;
      m_err   = 1'b0;
      if (r) begin
         byte_q.delete();
         idle_run   = 0;
         m_word_msb = 32'h0;
         m_word_lsb = 32'h0;
      end else if (v) begin
         byte_q.push_back(d);
         idle_run = 0;
         if (byte_q.size() == 4) begin
            m_word_msb = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
            m_word_lsb = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
            m_out32    = 1'b1;
            byte_q.delete();
         end
      end else if (byte_q.size() != 0) begin
         idle_run++;
`ifdef CONV_8_32_GAP_ABORT_EN
         if (idle_run == GAP_MAX) begin
            byte_q.delete();
            idle_run = 0;
            m_err    = 1'b1;
         end
`endif
      end
      m_busy = (byte_q.size() != 0);
   endtask

   task automatic checkOutput();
      checkVal("msb_out32",   32'(bus.out32),      32'(m_out32));
      checkVal("msb_word",    bus.out_data32,      m_word_msb);
      checkVal("msb_busy",    32'(bus.busy),       32'(m_busy));
      checkVal("msb_gap_err", 32'(bus.gap_err),    32'(m_err));
      checkVal("lsb_out32",   32'(bus_lsb.out32),  32'(m_out32));
      checkVal("lsb_word",    bus_lsb.out_data32,  m_word_lsb);
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
      reset        = r;
      bus.in8      = v;
      bus.in_data8 = d;
      @(posedge clk);
      modelStep(r, v, d);
      #1;
      checkOutput();
   endtask

   initial begin
      int err_pulses;
      int idle_burst;
      logic r, v;

      reset        = 1'b1;
      bus.in8      = 1'b0;
      bus.in_data8 = 8'h00;

      vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h00000000, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h00000000, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h00000000, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 32'hFFFFFFFF, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 8'hDD, 1'b0, 32'hFFFFFFFF, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 8'hDD, 1'b0, 32'hFFFFFFFF, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 8'hDD, 1'b0, 32'hFFFFFFFF, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 8'hDD, 1'b1, 32'hDDDDDDDD, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 32'hDDDDDDDD, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 32'hDDDDDDDD, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 32'hDDDDDDDD, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 8'h03, 1'b1, 32'h00000003, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 8'hA5, 1'b0, 32'h00000003, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 8'h5A, 1'b0, 32'h00000003, 1'b0};

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].d);
         checkVal($sformatf("vec%0d_out32", i), 32'(bus.out32), 32'(vecs[i].e_out32));
         checkVal($sformatf("vec%0d_word", i),  bus.out_data32, vecs[i].e_word);
         checkVal($sformatf("vec%0d_busy", i),  32'(bus.busy),  32'(vecs[i].e_busy));
      end

      // Short gap mid-word must keep the partial bytes.
      err_pulses = 0;
      applyStimulus(1'b0, 1'b1, 8'h11);
      applyStimulus(1'b0, 1'b1, 8'h22);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 8'hEE);
         err_pulses += int'(bus.gap_err);
      end
      applyStimulus(1'b0, 1'b1, 8'h33);
      applyStimulus(1'b0, 1'b1, 8'h44);
      checkVal("gap3_out32", 32'(bus.out32), 32'd1);
      checkVal("gap3_word", bus.out_data32, 32'h11223344);
      checkVal("gap3_no_err", 32'(err_pulses), 32'd0);

      // Reset mid-word drops the partial bytes.
      applyStimulus(1'b0, 1'b1, 8'hAA);
      applyStimulus(1'b0, 1'b1, 8'hBB);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkVal("rst_word", bus.out_data32, 32'h0);
      checkVal("rst_busy", 32'(bus.busy), 32'd0);
      applyStimulus(1'b0, 1'b1, 8'h01);
      applyStimulus(1'b0, 1'b1, 8'h02);
      applyStimulus(1'b0, 1'b1, 8'h03);
      applyStimulus(1'b0, 1'b1, 8'h04);
      checkVal("rst_new_word", bus.out_data32, 32'h01020304);
      checkVal("lsb_word_order", bus_lsb.out_data32, 32'h04030201);

      // Long gap: aborts with the timeout feature, otherwise bytes are held.
      err_pulses = 0;
      applyStimulus(1'b0, 1'b1, 8'h55);
      applyStimulus(1'b0, 1'b1, 8'h66);
      for (int i = 0; i < GAP_MAX; i++) begin
         applyStimulus(1'b0, 1'b0, 8'hC3);
         err_pulses += int'(bus.gap_err);
      end
`ifdef CONV_8_32_GAP_ABORT_EN
      checkVal("gap8_err_pulses", 32'(err_pulses), 32'd1);
      checkVal("gap8_busy", 32'(bus.busy), 32'd0);
      applyStimulus(1'b0, 1'b1, 8'h01);
      applyStimulus(1'b0, 1'b1, 8'h02);
      applyStimulus(1'b0, 1'b1, 8'h03);
      applyStimulus(1'b0, 1'b1, 8'h04);
      checkVal("gap8_new_word", bus.out_data32, 32'h01020304);
`else
      checkVal("gap8_err_pulses", 32'(err_pulses), 32'd0);
      checkVal("gap8_busy", 32'(bus.busy), 32'd1);
      applyStimulus(1'b0, 1'b1, 8'h01);
      applyStimulus(1'b0, 1'b1, 8'h02);
      checkVal("gap8_held_word", bus.out_data32, 32'h55660102);
      checkVal("gap8_held_out32", 32'(bus.out32), 32'd1);
`endif
      applyStimulus(1'b1, 1'b0, 8'h00);

      // Random traffic with occasional long idle bursts and rare resets.
      idle_burst = 0;
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 249) == 0);
         if (idle_burst > 0) begin
            v = 1'b0;
            idle_burst--;
         end else if ($urandom_range(0, 29) == 0) begin
            v = 1'b0;
            idle_burst = $urandom_range(1, 12);
         end else begin
            v = ($urandom_range(0, 3) != 0);
         end
         applyStimulus(r, v, 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
